spike_encoder: RTL and testbench

Rate-coding spike encoder: turns an 8-bit intensity into a spike train plus a weighted synaptic-current word, in the format the membrane-integrating neuron decoder consumes as I_syn.
It sits upstream of the neuron decoder inside the tt_um top level, driven from the ui_in switches.
It offers a deterministic (phase-accumulator) mode and a stochastic (LFSR) mode, optional refractory suppression, and a per-window spike count for readback.

---
 rtl/spike_encoder.sv | 165 ++++++++++++++++
 tb/tb_spike_encoder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_encoder.sv
// Rate-coding spike encoder: turns an 8-bit intensity into a spike train and a
// weighted synaptic-current word (I_syn) for the downstream neuron decoder.
// Deterministic mode uses a phase accumulator; stochastic mode compares an
// 8-bit Fibonacci LFSR against the intensity. Optional refractory quiet time
// follows each spike, and spikes are counted per window for readback.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no output activity; LFSR still free-runs while enabled
// RUN    | encoding; candidates are emitted as spikes
// REFRAC | quiet period after a spike; acc/LFSR advance, candidates dropped
module spike_encoder #(
    parameter int         WINDOW_LEN = 256,
    parameter int         REFRACTORY = 0,
    parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] value,
    input  logic [7:0] weight,
    input  logic       mode,
    input  logic       load,
    output logic       spike,
    output logic [7:0] i_syn,
    output logic [7:0] spike_count,
    output logic       window_done
);

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [7:0] SEED_EFF    = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
    localparam logic [8:0] WIN_LAST    = 9'(WINDOW_LEN - 1);
    localparam logic [3:0] REFRAC_LOAD = 4'(REFRACTORY);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        REFRAC = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;

    logic [7:0] value_reg;
    logic [7:0] weight_reg;
    logic       mode_reg;
    logic [7:0] acc;
    logic [7:0] lfsr;
    logic [7:0] live_cnt;
    logic [8:0] win_cnt;
    logic [3:0] refrac_cnt;

    logic       lfsr_fb;
    logic [7:0] lfsr_nxt;
    logic [8:0] acc_sum;
    logic       candidate;
    logic       step;
    logic       fire;
    logic       win_end;
    logic       enter_refrac;
    logic [7:0] live_inc;

    // Datapath decode: LFSR feedback, accumulator carry, step/fire/window qualifiers.
    always_comb begin
        lfsr_fb      = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
        lfsr_nxt     = {lfsr[6:0], lfsr_fb};
        acc_sum      = {1'b0, acc} + {1'b0, value_reg};
        candidate    = mode_reg ? (lfsr < value_reg) : acc_sum[8];
        step         = ena & ~load & (state != IDLE);
        fire         = step & candidate & (state == RUN);
        win_end      = step & (win_cnt == WIN_LAST);
        enter_refrac = fire & (REFRACTORY > 0);
        live_inc     = (live_cnt == 8'hFF) ? 8'hFF : (live_cnt + {7'd0, fire});
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; load from any state restarts the encoder in RUN.
    always_comb begin
        state_nxt = state;
        if (ena) begin
            if (load) begin
                state_nxt = RUN;
            end else begin
                case (state)
                    RUN: begin
                        if (enter_refrac) begin
                            state_nxt = REFRAC;
                        end
                    end
                    REFRAC: begin
                        // Counter hits zero on this edge: quiet period is over.
                        if (refrac_cnt <= 4'd1) begin
                            state_nxt = RUN;
                        end
                    end
                    default: state_nxt = state;
                endcase
            end
        end
    end

    // Input capture, accumulator, LFSR, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_reg   <= 8'h00;
            weight_reg  <= 8'h00;
            mode_reg    <= 1'b0;
            acc         <= 8'h00;
            lfsr        <= SEED_EFF;
            live_cnt    <= 8'h00;
            win_cnt     <= 9'd0;
            refrac_cnt  <= 4'd0;
            spike       <= 1'b0;
            i_syn       <= 8'h00;
            spike_count <= 8'h00;
            window_done <= 1'b0;
        end else if (ena) begin
            lfsr        <= lfsr_nxt;
            spike       <= 1'b0;
            i_syn       <= 8'h00;
            window_done <= 1'b0;
            if (load) begin
                value_reg  <= value;
                weight_reg <= weight;
                mode_reg   <= mode;
                acc        <= 8'h00;
                live_cnt   <= 8'h00;
                win_cnt    <= 9'd0;
                refrac_cnt <= 4'd0;
            end else if (step) begin
                acc   <= acc_sum[7:0];
                spike <= fire;
                i_syn <= fire ? weight_reg : 8'h00;
                if (enter_refrac) begin
                    refrac_cnt <= REFRAC_LOAD;
                end else if ((state == REFRAC) && (refrac_cnt != 4'd0)) begin
                    refrac_cnt <= refrac_cnt - 4'd1;
                end
                if (win_end) begin
                    spike_count <= live_inc;
                    window_done <= 1'b1;
                    win_cnt     <= 9'd0;
                    live_cnt    <= 8'h00;
                end else begin
                    win_cnt  <= win_cnt + 9'd1;
                    live_cnt <= live_inc;
                end
            end
        end else begin
            // Paused: everything holds, but pulses must not stretch.
            spike       <= 1'b0;
            i_syn       <= 8'h00;
            window_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spike_encoder.sv
// Bench for spike_encoder: three instances (default, REFRACTORY=1,
// WINDOW_LEN=255) share stimulus; a behavioural model pushes expected
// outputs per edge into a scoreboard that is popped after each edge.
module tb_spike_encoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] value;
    logic [7:0] weight;
    logic       mode;
    logic       load;

    logic       sp [3];
    logic [7:0] is [3];
    logic [7:0] ct [3];
    logic       dn [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    spike_encoder u_def (
        .clk(clk), .rst_n(rst_n), .ena(ena), .value(value), .weight(weight),
        .mode(mode), .load(load), .spike(sp[0]), .i_syn(is[0]),
        .spike_count(ct[0]), .window_done(dn[0]));

    spike_encoder #(.REFRACTORY(1)) u_ref (
        .clk(clk), .rst_n(rst_n), .ena(ena), .value(value), .weight(weight),
        .mode(mode), .load(load), .spike(sp[1]), .i_syn(is[1]),
        .spike_count(ct[1]), .window_done(dn[1]));

    spike_encoder #(.WINDOW_LEN(255)) u_win (
        .clk(clk), .rst_n(rst_n), .ena(ena), .value(value), .weight(weight),
        .mode(mode), .load(load), .spike(sp[2]), .i_syn(is[2]),
        .spike_count(ct[2]), .window_done(dn[2]));

    typedef struct packed {
        logic       sp;
        logic [7:0] isyn;
        logic [7:0] cnt;
        logic       dn;
    } exp_t;

    exp_t sb_q [$];

    int P_WL [3] = '{256, 256, 255};
    int P_RF [3] = '{0, 1, 0};

    // model state: st 0=idle 1=run 2=refrac
    int         m_st   [3];
    int         m_win  [3];
    int         m_rc   [3];
    logic [7:0] m_v    [3];
    logic [7:0] m_w    [3];
    logic       m_m    [3];
    logic [7:0] m_acc  [3];
    logic [7:0] m_lfsr [3];
    logic [7:0] m_live [3];
    logic [7:0] m_cnt  [3];

    // observation counters for test-plan checks
    int n_sp0, n_sp2, done_seen, done_cyc, cyc, consec1;
    logic prev_sp1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_st[i] = 0; m_win[i] = 0; m_rc[i] = 0;
            m_v[i] = 8'h00; m_w[i] = 8'h00; m_m[i] = 1'b0;
            m_acc[i] = 8'h00; m_lfsr[i] = 8'hA5; m_live[i] = 8'h00; m_cnt[i] = 8'h00;
        end
    endtask

    task automatic model_step(input int i);
        logic [7:0] cur;
        logic [8:0] sum;
        logic       cand;
        logic       s;
        logic [7:0] nl;
        exp_t       e;
        e = '0;
        if (ena) begin
            cur = m_lfsr[i];
            m_lfsr[i] = {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
            if (load) begin
                m_v[i] = value; m_w[i] = weight; m_m[i] = mode;
                m_acc[i] = 8'h00; m_live[i] = 8'h00; m_win[i] = 0; m_rc[i] = 0;
                m_st[i] = 1;
            end else if (m_st[i] != 0) begin
                sum = {1'b0, m_acc[i]} + {1'b0, m_v[i]};
                m_acc[i] = sum[7:0];
                cand = m_m[i] ? (cur < m_v[i]) : sum[8];
                s = cand && (m_st[i] == 1);
                if (m_st[i] == 1 && s && P_RF[i] > 0) begin
                    m_st[i] = 2; m_rc[i] = P_RF[i];
                end else if (m_st[i] == 2) begin
                    m_rc[i]--;
                    if (m_rc[i] == 0) m_st[i] = 1;
                end
                nl = (m_live[i] == 8'hFF) ? 8'hFF : m_live[i] + {7'd0, s};
                m_win[i]++;
                if (m_win[i] == P_WL[i]) begin
                    m_cnt[i] = nl; e.dn = 1'b1; m_win[i] = 0; m_live[i] = 8'h00;
                end else begin
                    m_live[i] = nl;
                end
                e.sp = s;
                e.isyn = s ? m_w[i] : 8'h00;
            end
        end
        e.cnt = m_cnt[i];
        sb_q.push_back(e);
    endtask

    task automatic clr_obs();
        n_sp0 = 0; n_sp2 = 0; done_seen = 0; done_cyc = -1; cyc = 0;
        consec1 = 0; prev_sp1 = 1'b0;
    endtask

    task automatic cycle(input logic e, input logic l, input logic [7:0] v,
                         input logic [7:0] w, input logic m);
        exp_t ex;
        ena = e; load = l; value = v; weight = w; mode = m;
        for (int i = 0; i < 3; i++) model_step(i);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 32'd0, 32'd1);
            end else begin
                ex = sb_q.pop_front();
                check($sformatf("spike%0d", i), 32'(sp[i]), 32'(ex.sp));
                check($sformatf("i_syn%0d", i), 32'(is[i]), 32'(ex.isyn));
                check($sformatf("count%0d", i), 32'(ct[i]), 32'(ex.cnt));
                check($sformatf("done%0d", i), 32'(dn[i]), 32'(ex.dn));
            end
        end
        if (sp[0]) n_sp0++;
        if (sp[2]) n_sp2++;
        if (dn[0]) begin done_seen++; done_cyc = cyc; end
        if (sp[1] && prev_sp1) consec1++;
        prev_sp1 = sp[1];
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) cycle(1'b1, 1'b0, value, weight, mode);
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b0; load = 1'b0; value = 8'h00; weight = 8'h00; mode = 1'b0;
        model_reset();
        #3;
        for (int i = 0; i < 3; i++) begin
            check("rst_spike", 32'(sp[i]), 32'd0);
            check("rst_i_syn", 32'(is[i]), 32'd0);
            check("rst_count", 32'(ct[i]), 32'd0);
            check("rst_done", 32'(dn[i]), 32'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run(3);

        // 50% duty deterministic, one full window
        clr_obs();
        cycle(1'b1, 1'b1, 8'd128, 8'h40, 1'b0);
        run(256);
        check("a_spikes", 32'(n_sp0), 32'd128);
        check("a_done_n", 32'(done_seen), 32'd1);
        check("a_count", 32'(ct[0]), 32'd128);

        // value 0 never spikes, then full-scale
        clr_obs();
        cycle(1'b1, 1'b1, 8'd0, 8'h11, 1'b0);
        run(256);
        check("b0_spikes", 32'(n_sp0), 32'd0);
        check("b0_count", 32'(ct[0]), 32'd0);
        clr_obs();
        cycle(1'b1, 1'b1, 8'd255, 8'h22, 1'b0);
        run(256);
        check("b255_count", 32'(ct[0]), 32'd255);
        check("refr_consec", 32'(consec1), 32'd0);
        check("refr_le128", 32'(ct[1] <= 8'd128), 32'd1);

        // stochastic, window 255: LFSR visits 0xFF exactly once
        clr_obs();
        cycle(1'b1, 1'b1, 8'd255, 8'h33, 1'b1);
        run(255);
        check("c_count", 32'(ct[2]), 32'd254);
        check("c_spikes", 32'(n_sp2), 32'd254);
        clr_obs();
        cycle(1'b1, 1'b1, 8'd0, 8'h33, 1'b1);
        run(255);
        check("c0_count", 32'(ct[2]), 32'd0);
        check("c0_spikes", 32'(n_sp2), 32'd0);

        // pause: unpaused reference then 10-cycle ena drop
        clr_obs();
        cycle(1'b1, 1'b1, 8'd100, 8'h05, 1'b0);
        run(256);
        check("d_ref_cyc", 32'(done_cyc), 32'd256);
        check("d_ref_count", 32'(ct[0]), 32'd100);
        clr_obs();
        cycle(1'b1, 1'b1, 8'd100, 8'h05, 1'b0);
        run(50);
        repeat (10) cycle(1'b0, 1'b0, 8'd100, 8'h05, 1'b0);
        run(206);
        check("d_pause_cyc", 32'(done_cyc), 32'd266);
        check("d_pause_count", 32'(ct[0]), 32'd100);

        // load coincident with window end: load wins
        clr_obs();
        cycle(1'b1, 1'b1, 8'd128, 8'h40, 1'b0);
        run(255);
        cycle(1'b1, 1'b1, 8'd128, 8'h40, 1'b0);
        check("e_done", 32'(dn[0]), 32'd0);
        check("e_count", 32'(ct[0]), 32'd100);

        // async reset between edges at step 100
        run(100);
        check("f_pre_spike", 32'(sp[0]), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("f_spike", 32'(sp[i]), 32'd0);
            check("f_i_syn", 32'(is[i]), 32'd0);
            check("f_count", 32'(ct[i]), 32'd0);
            check("f_done", 32'(dn[i]), 32'd0);
        end
        #1;
        rst_n = 1'b1;
        model_reset();
        sb_q.delete();
        clr_obs();
        run(20);
        check("f_idle_spikes", 32'(n_sp0), 32'd0);

        // random loads, enables and mid-window reloads
        for (int k = 0; k < 6; k++) begin
            cycle(1'b1, 1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)));
            for (int j = 0; j < 300; j++) begin
                cycle(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 199) == 0),
                      8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                      1'($urandom_range(0, 1)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
